// File: rtl/icache_fill_ctrl.sv
// Direct-mapped instruction cache with a single-outstanding-line refill sequencer.
// Optional ICACHE_FLUSH_EN adds a Flush input that invalidates every line.
`timescale 1ns/1ps

module icache_fill_ctrl #(
    parameter int dataW = 32,
    parameter int LINES = 8,
    parameter int WORDS = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [dataW-1:0] ProgAddr,
    output logic [dataW-1:0] Instruction,
    output logic             InsCacheStall,
    output logic             MemReq,
    output logic [dataW-1:0] MemAddr,
    input  logic             MemAck,
    input  logic [dataW-1:0] MemData
`ifdef ICACHE_FLUSH_EN
    ,
    input  logic             Flush
`endif
);

    localparam int OFFW = $clog2(WORDS);
    localparam int IDXW = $clog2(LINES);
    localparam int LSB  = OFFW + 2;
    localparam int TAGW = dataW - IDXW - LSB;
    localparam logic [OFFW-1:0] BEAT_LAST = OFFW'(WORDS - 1);

    typedef enum logic {
        IDLE,
        FILL
    } state_t;

    state_t stateReg, stateNext;

    logic [OFFW-1:0]  offBits;
    logic [IDXW-1:0]  idxBits;
    logic [TAGW-1:0]  tagBits;
    logic [1:0]       unusedAddrBits;

    logic [dataW-1:0] dataMem [LINES][WORDS];
    logic [TAGW-1:0]  tagMem  [LINES];
    logic [LINES-1:0] validReg;

    logic [IDXW-1:0]  idxReg;
    logic [TAGW-1:0]  tagReg;
    logic [OFFW-1:0]  beatReg;

    logic hit;
    logic startFill;
    logic beatWrite;
    logic lastBeat;
    logic flushReq;
    logic flushBlock;

    assign offBits        = ProgAddr[LSB-1:2];
    assign idxBits        = ProgAddr[LSB +: IDXW];
    assign tagBits        = ProgAddr[dataW-1 -: TAGW];
    assign unusedAddrBits = ProgAddr[1:0];

    assign hit           = validReg[idxBits] && (tagMem[idxBits] == tagBits);
    assign Instruction   = dataMem[idxBits][offBits];
    assign InsCacheStall = (stateReg != IDLE) || !hit;
    assign MemReq        = (stateReg == FILL);
    // {tag, idx, beat, 00} is exactly line base + 4*beat
    assign MemAddr       = (stateReg == FILL) ? {tagReg, idxReg, beatReg, 2'b00} : '0;

`ifdef ICACHE_FLUSH_EN
    logic flushSeenReg;
    assign flushReq   = Flush;
    assign flushBlock = flushSeenReg || Flush;
`else
    assign flushReq   = 1'b0;
    assign flushBlock = 1'b0;
`endif

    always_comb begin
        stateNext = stateReg;
        startFill = 1'b0;
        beatWrite = 1'b0;
        lastBeat  = 1'b0;
        case (stateReg)
            IDLE: begin
                // a simultaneous flush takes priority; the fill starts a cycle later
                if (!flushReq && !hit) begin
                    startFill = 1'b1;
                    stateNext = FILL;
                end
            end
            FILL: begin
                if (MemAck) begin
                    beatWrite = 1'b1;
                    if (beatReg == BEAT_LAST) begin
                        lastBeat  = 1'b1;
                        stateNext = IDLE;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stateReg <= IDLE;
            beatReg  <= '0;
            validReg <= '0;
`ifdef ICACHE_FLUSH_EN
            flushSeenReg <= 1'b0;
`endif
        end else begin
            stateReg <= stateNext;
            if (startFill) begin
                beatReg           <= '0;
                validReg[idxBits] <= 1'b0;
            end else if (beatWrite) begin
                beatReg <= beatReg + 1'b1;
            end
            if (lastBeat && !flushBlock) begin
                validReg[idxReg] <= 1'b1;
            end
`ifdef ICACHE_FLUSH_EN
            if (Flush) begin
                validReg <= '0;
            end
            // remembers a flush seen mid-fill so the final beat stays invalid
            flushSeenReg <= (stateReg == FILL) && !lastBeat && (flushSeenReg || Flush);
`endif
        end
    end

    // storage arrays are deliberately not reset; validReg guards them
    always_ff @(posedge clock) begin
        if (startFill) begin
            idxReg <= idxBits;
            tagReg <= tagBits;
        end
        if (beatWrite) begin
            dataMem[idxReg][beatReg] <= MemData;
        end
        if (lastBeat) begin
            tagMem[idxReg] <= tagReg;
        end
    end

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Scoreboard bench for icache_fill_ctrl: directed cases then randomized fetches
// against a line-number based cache model and a hashed backing memory.
`timescale 1ns/1ps

module tb_icache_fill_ctrl;

    localparam int dataW = 32;
    localparam int LINES = 8;
    localparam int WORDS = 4;
    localparam int LINE_BYTES = WORDS * 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] ProgAddr = '0;
    logic [31:0] Instruction;
    logic        InsCacheStall;
    logic        MemReq;
    logic [31:0] MemAddr;
    logic        MemAck = 1'b0;
    logic [31:0] MemData;
`ifdef ICACHE_FLUSH_EN
    logic        Flush = 1'b0;
`endif

    always #5 clock = ~clock;

    icache_fill_ctrl #(.dataW(dataW), .LINES(LINES), .WORDS(WORDS)) dut (
        .clock        (clock),
        .reset        (reset),
        .ProgAddr     (ProgAddr),
        .Instruction  (Instruction),
        .InsCacheStall(InsCacheStall),
        .MemReq       (MemReq),
        .MemAddr      (MemAddr),
        .MemAck       (MemAck),
        .MemData      (MemData)
`ifdef ICACHE_FLUSH_EN
        ,
        .Flush        (Flush)
`endif
    );

    function automatic logic [31:0] memWord(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        return (w * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    assign MemData = memWord(MemAddr);

    typedef struct {
        logic [31:0] addr;
        logic [31:0] word;
        int          expStall;
    } fetch_t;

    fetch_t      fetchQ[$];
    logic [31:0] memQ[$];
    int          checks = 0;
    int          errors = 0;
    int          ackMode = 0;
    int          stallCnt = 0;

    bit          modelValid[LINES];
    int unsigned modelTag[LINES];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic modelInvalidate();
        for (int i = 0; i < LINES; i++) modelValid[i] = 1'b0;
    endtask

    // Cache model in terms of line numbers: line n lives in slot n % LINES.
    task automatic prepare(input logic [31:0] a);
        int unsigned line;
        int unsigned slot;
        int unsigned tag;
        bit          isHit;
        fetch_t      e;
        line  = a / LINE_BYTES;
        slot  = line % LINES;
        tag   = line / LINES;
        isHit = modelValid[slot] && (modelTag[slot] == tag);
        e.addr = a;
        e.word = memWord(a);
        e.expStall = isHit ? 0 : ((ackMode == 0) ? WORDS + 1 : -1);
        if (!isHit) begin
            for (int k = 0; k < WORDS; k++) memQ.push_back(line * LINE_BYTES + 4 * k);
            modelValid[slot] = 1'b1;
            modelTag[slot]   = tag;
        end
        fetchQ.push_back(e);
        ProgAddr = a;
    endtask

    task automatic waitDone();
        for (int c = 0; c < 300 && fetchQ.size() != 0; c++) @(posedge clock);
        if (fetchQ.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL fetch_timeout: addr %h still stalled, expected completion within 300 cycles",
                     fetchQ[0].addr);
            fetchQ.delete();
            memQ.delete();
        end
        #1;
    endtask

    task automatic fetch(input logic [31:0] a);
        prepare(a);
        waitDone();
    endtask

    // Memory responder: ack pattern selected by ackMode.
    initial begin
        int cyc;
        cyc = 0;
        forever begin
            @(posedge clock);
            #1;
            case (ackMode)
                0:       MemAck = 1'b1;
                1:       MemAck = (cyc % 3 == 2);
                default: MemAck = 1'($urandom_range(0, 1));
            endcase
            cyc++;
        end
    end

    // Beat monitor: each requested beat must match the next expected line address.
    always @(negedge clock) begin
        if (reset && MemReq) begin
            checks++;
            if (memQ.size() == 0) begin
                errors++;
                $display("FAIL mem_unexpected: MemReq=1 MemAddr=%h, expected no request", MemAddr);
            end else begin
                if (MemAddr !== memQ[0]) begin
                    errors++;
                    $display("FAIL mem_addr: got %h expected %h", MemAddr, memQ[0]);
                end
                if (MemAck) void'(memQ.pop_front());
            end
        end
    end

    // Fetch monitor: completes the oldest fetch on the first non-stalled cycle.
    always @(negedge clock) begin
        fetch_t e;
        if (!reset) begin
            stallCnt = 0;
        end else if (fetchQ.size() > 0) begin
            if (InsCacheStall) begin
                stallCnt++;
            end else begin
                e = fetchQ.pop_front();
                checks += 3;
                if (Instruction !== e.word) begin
                    errors++;
                    $display("FAIL fetch_data: addr %h got %h expected %h", e.addr, Instruction, e.word);
                end
                if (MemReq !== 1'b0) begin
                    errors++;
                    $display("FAIL fetch_memreq: addr %h got MemReq=%b expected 0", e.addr, MemReq);
                end
                if (e.expStall >= 0 ? (stallCnt != e.expStall) : (stallCnt < WORDS + 1)) begin
                    errors++;
                    $display("FAIL fetch_stall: addr %h got %0d stall cycles expected %0d (-1 means >=%0d)",
                             e.addr, stallCnt, e.expStall, WORDS + 1);
                end
                $display("fetch addr=%h instr=%h stalls=%0d", e.addr, Instruction, stallCnt);
                stallCnt = 0;
            end
        end
    end

    initial begin
        logic [31:0] a;
        modelInvalidate();
        repeat (3) @(posedge clock);
        #1;
        check("reset_memreq", {31'b0, MemReq}, 32'd0);
        check("reset_memaddr", MemAddr, 32'd0);
        check("reset_stall", {31'b0, InsCacheStall}, 32'd1);

        // cold miss at 0, then hits across the line
        ackMode = 0;
        prepare(32'h0);
        @(posedge clock);
        #1 reset = 1'b1;
        waitDone();
        fetch(32'h4);
        fetch(32'h8);
        fetch(32'hC);

`ifdef ICACHE_FLUSH_EN
        Flush = 1'b1;
        @(posedge clock);
        #1 Flush = 1'b0;
        modelInvalidate();
        fetch(32'h0);
`endif

        // conflict eviction in slot 0, ignored low address bits
        fetch(32'h80);
        fetch(32'h8E);
        fetch(32'h1);
        fetch(32'h84);

        // backpressure
        ackMode = 1;
        fetch(32'h40);
        fetch(32'h4C);

        // reset in the middle of a fill
        ackMode = 0;
        prepare(32'h20);
        for (int c = 0; c < 50 && memQ.size() > 2; c++) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check("midfill_memreq", {31'b0, MemReq}, 32'd0);
        check("midfill_memaddr", MemAddr, 32'd0);
        check("midfill_stall", {31'b0, InsCacheStall}, 32'd1);
        fetchQ.delete();
        memQ.delete();
        modelInvalidate();
        @(posedge clock);
        prepare(32'h20);
        @(posedge clock);
        #1 reset = 1'b1;
        waitDone();
        fetch(32'h24);

        // randomized fetch stream
        for (int n = 0; n < 300; n++) begin
            ackMode = $urandom_range(0, 2);
            a = 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 7) == 0) a = a | 32'hFFFF_F000;
            fetch(a);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/icache_fill_ctrl.md
Name: icache_fill_ctrl

Overview:
Direct-mapped instruction cache with its refill sequencer, sitting between the PC and instruction memory. Looks up ProgAddr every cycle and returns the instruction word on a hit. On a miss it raises InsCacheStall to freeze the PC, fetches the whole line from memory with a req/ack beat handshake, then installs the line. Stall drops on the first cycle the lookup hits.

Parameters:
dataW, 32, address and instruction word width
LINES, 8, number of cache lines; power of 2, at least 2
WORDS, 4, 32-bit words per line; power of 2, at least 2

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset; low clears the block immediately
ProgAddr  in  dataW  fetch address from the PC
Instruction  out  dataW  fetched instruction word; valid only while InsCacheStall=0
InsCacheStall  out  1  high while ProgAddr misses or a refill is in progress
MemReq  out  1  beat request to instruction memory
MemAddr  out  dataW  word-aligned beat address; bits[1:0]=0
MemAck  in  1  memory accepted the beat and MemData is valid this cycle
MemData  in  dataW  beat read data
Flush  in  1  invalidate all lines (only present when ICACHE_FLUSH_EN is defined)

Behaviour:
- Address split: off = ProgAddr[log2(WORDS)+1:2]; idx = next log2(LINES) bits; tag = the remaining upper bits. ProgAddr[1:0] is ignored.
- Storage: data array LINES x WORDS x dataW, tag array, and one valid bit per line. All storage is registers.
- hit = valid[idx] && tag_store[idx]==tag, evaluated combinationally.
- Instruction = data[idx][off], combinational. Hit latency is 0 cycles.
- InsCacheStall = (state!=IDLE) || !hit. This is combinational, so the PC holds on the same cycle a miss appears.
- FSM states:
  - IDLE: on !hit, latch line base {ProgAddr[dataW-1:log2(WORDS)+2], zeros} plus idx/tag; clear the beat counter; go to FILL.
  - FILL: MemReq=1 and MemAddr=base+4*beat. Both stay stable until MemAck. On MemAck, write MemData to data[idx_l][beat] and increment beat. On MemAck with beat==WORDS-1, write tag_store[idx_l]=tag_l, set valid[idx_l]=1, and go to IDLE.
- Miss penalty with MemAck tied high is WORDS+1 cycles from the miss cycle to the first hit cycle.
- MemAck while MemReq=0 is ignored. MemData is sampled only on MemReq&&MemAck.
- ProgAddr changes during FILL are ignored; the latched line completes. On return to IDLE the lookup re-evaluates, so a different missing address starts a new fill on the next edge.
- A refill replaces the line at idx_l unconditionally (no replacement policy, direct mapped).
- A half-filled line is never visible: valid is set only on the final beat, and valid[idx_l] is cleared on entry to FILL.
- Reset (low, any time, including mid-FILL): state=IDLE, beat=0, all valid bits=0, MemReq=0, MemAddr=0. Data and tag arrays are not reset. After reset InsCacheStall=1, because every lookup misses.
- Outputs after reset: MemReq=0, MemAddr=0, InsCacheStall=1, Instruction=don't-care.

Optional Feature:
ICACHE_FLUSH_EN
- Defined: the Flush port exists. Flush high in IDLE clears all valid bits at the next edge; the stall follows from the resulting misses. Flush high during FILL lets the fill complete, but the final beat does not set valid, and all valid bits are cleared. Flush and a miss in the same IDLE cycle: the flush wins, the FSM stays in IDLE that cycle, and the fill starts on the next cycle.
- Undefined: no Flush port. Lines are invalidated only by reset.

Test Plan:
1. Cold miss: release reset, ProgAddr=0x00000000, MemAck=1 every cycle, MemData=0x1000+beat -> MemAddr 0x0,0x4,0x8,0xC on consecutive cycles; InsCacheStall=1 for 5 cycles, then 0 with Instruction=0x1000.
2. Line hits: after test 1, step ProgAddr through 0x4, 0x8, 0xC -> InsCacheStall=0 each cycle, Instruction=0x1001, 0x1002, 0x1003, MemReq=0.
3. Conflict eviction: ProgAddr=0x00000080 (same idx 0, new tag, defaults) -> refill from 0x80..0x8C; then ProgAddr=0x0 -> misses again and refetches.
4. Backpressure: miss at 0x40, MemAck high only every third cycle -> MemReq and MemAddr held stable between acks; four writes total; stall drops one cycle after the fourth ack.
5. Reset mid-fill: miss at 0x20, reset pulsed low after 2 beats -> MemReq=0 immediately; after release, 0x20 misses again and MemAddr restarts at 0x20.
6. (ICACHE_FLUSH_EN) Flush for one cycle after test 2, then ProgAddr=0x0 -> InsCacheStall=1 and a refill starts from 0x0.
